// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions. These are the default clock and line
//            rates, the derived bit-period divider and counter width, and
//            the receiver state encoding used by both the receiver and the
//            transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned c_default_freq = 12000000;
    localparam int unsigned c_default_baud = 9600;
    localparam int unsigned c_div          = c_default_freq / c_default_baud;
    localparam int unsigned c_cnt_w        = $clog2(c_div);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Purpose  : Two-flop synchronizer that brings an asynchronous level into
//            the clk domain. Both flops reset to 1, so an idle-high serial
//            line does not show a false start edge when reset is released.
// Ports    : clk  - system clock
//            nrst - asynchronous active-low reset
//            i_d  - asynchronous input
//            o_q  - synchronized output (two cycles of latency)
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync2 (
    input  logic clk,
    input  logic nrst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver. The start bit is detected on the
//            synchronized line, is re-checked at mid-bit, and each later bit
//            is sampled one bit period apart. A correctly framed byte is held
//            in rx_data with rx_valid until the consumer acknowledges it.
//            Reception never waits for the consumer.
// Ports    : clk       - system clock
//            nrst      - asynchronous active-low reset
//            rx        - serial line (asynchronous, idle high)
//            rx_data   - last correctly framed byte
//            rx_valid  - rx_data holds an unacknowledged byte
//            rx_ack    - consumer accepts rx_data
//            frame_err - one-cycle pulse when the stop bit is sampled low
//            overrun   - sticky flag: a byte completed while rx_valid was high
//            busy      - receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned FREQ = c_default_freq,
    parameter int unsigned BAUD = c_default_baud
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned c_bit_div = FREQ / BAUD;
    localparam int unsigned c_bit_w   = $clog2(c_bit_div);
    localparam logic [c_bit_w-1:0] c_cnt_last = c_bit_w'(c_bit_div - 1);
    localparam logic [c_bit_w-1:0] c_cnt_half = c_bit_w'(c_bit_div / 2 - 1);

    logic               w_rs;
    rx_state_t          r_state;
    rx_state_t          w_state_nxt;
    logic [c_bit_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               r_overrun;

    logic w_cnt_clr;
    logic w_sample;
    logic w_load;
    logic w_ferr;
    logic w_cnt_last;
    logic w_cnt_half;

    uart_sync2 u_sync (
        .clk  (clk),
        .nrst (nrst),
        .i_d  (rx),
        .o_q  (w_rs)
    );

    assign w_cnt_last = (r_cnt == c_cnt_last);
    assign w_cnt_half = (r_cnt == c_cnt_half);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_sample    = 1'b0;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rs) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                // Mid-start-bit check: a line that is already high again was a glitch.
                if (w_cnt_half) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_rs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_cnt_last) begin
                    w_sample = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_cnt_last) begin
                    if (w_rs) begin
                        w_load      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line returns high so that a long low
                // break is not taken as a new start bit.
                w_cnt_clr = 1'b1;
                if (w_rs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bit-period counter. It wraps at the end of every bit in DATA and STOP,
    // so each data bit is sampled one full period after the previous one.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr || w_cnt_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if (r_state == IDLE) begin
                r_bit_idx <= 3'd0;
            end else if (w_sample) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_sample) begin
                r_shift[r_bit_idx] <= w_rs;
            end
        end
    end

    // Output holding register. When a new byte arrives in the same cycle as
    // an acknowledge, the old byte is consumed and the new byte takes its
    // place, so this is not an overrun.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                if (r_rx_valid && !rx_ack) begin
                    r_overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. A frame-level reference model
//            predicts every output on every cycle from the line level and
//            the bit-time arithmetic. Directed scenarios add literal checks
//            for latency, overrun, frame errors, glitches and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_div  = 1250;
    localparam int c_half = 625;

    logic       clk = 1'b0;
    logic       nrst;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int shown  = 0;
    int ferr_pulses = 0;
    int e0  = -1;
    int lat = -1;

    always #5 clk = ~clk;

    uart_rx #(.FREQ(12000000), .BAUD(9600)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Reference model. The mode is 0 for idle, 1 for inside a frame and 2
    // for waiting out a break. m_t is the number of edges since the start
    // edge was seen on the synchronized line.
    bit       m_valid = 1'b0;
    bit       m_ferr  = 1'b0;
    bit       m_ovr   = 1'b0;
    bit       m_busy  = 1'b0;
    bit [7:0] m_data  = 8'h00;
    bit [7:0] m_byte  = 8'h00;
    int       m_mode  = 0;
    int       m_t     = 0;
    bit       s1 = 1'b1;
    bit       s2 = 1'b1;

    always @(posedge clk) begin
        bit rs;
        bit nv;
        cyc++;
        if (!nrst) begin
            m_valid = 0; m_ferr = 0; m_ovr = 0; m_busy = 0;
            m_data = 8'h00; m_mode = 0; m_t = 0; s1 = 1; s2 = 1;
        end else begin
            rs = s2;
            nv = m_valid && !rx_ack;
            m_ferr = 0;
            case (m_mode)
                0: if (!rs) begin m_mode = 1; m_t = 0; end
                1: begin
                    m_t++;
                    if (m_t == c_half) begin
                        if (rs) m_mode = 0;
                    end else if (m_t > c_half && m_t < c_half + 9*c_div
                                 && (m_t - c_half) % c_div == 0) begin
                        m_byte[(m_t - c_half)/c_div - 1] = rs;
                    end else if (m_t == c_half + 9*c_div) begin
                        if (rs) begin
                            if (m_valid && !rx_ack) m_ovr = 1;
                            m_data = m_byte;
                            nv = 1;
                            m_mode = 0;
                        end else begin
                            m_ferr = 1;
                            m_mode = 2;
                        end
                    end
                end
                default: if (rs) m_mode = 0;
            endcase
            m_valid = nv;
            m_busy  = (m_mode != 0);
            s2 = s1;
            s1 = rx;
        end
    end

    // Per-cycle comparison, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        checks++;
        if (rx_valid !== m_valid || rx_data !== m_data || frame_err !== m_ferr ||
            overrun !== m_ovr || busy !== m_busy) begin
            errors++;
            if (shown < 20) begin
                shown++;
                $display("FAIL model cycle %0d: got valid=%b data=%h ferr=%b ovr=%b busy=%b, want valid=%b data=%h ferr=%b ovr=%b busy=%b",
                         cyc, rx_valid, rx_data, frame_err, overrun, busy,
                         m_valid, m_data, m_ferr, m_ovr, m_busy);
            end
        end
        if (frame_err === 1'b1) ferr_pulses++;
        // Cycle k runs from edge E0+k-1 to edge E0+k, where E0 is the
        // edge that enters START.
        if (lat < 0) begin
            if (e0 < 0 && busy === 1'b1) e0 = cyc;
            if (e0 >= 0 && rx_valid === 1'b1) lat = cyc - e0 + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
        rx = 1'b0;
        repeat (c_div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (c_div) @(negedge clk);
        end
        rx = stop;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; rx = 1'b1; rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_data", int'(rx_data), 8'h00);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ovr", int'(overrun), 0);
        nrst = 1'b1;
        repeat (20) @(negedge clk);

        // Single byte with no acknowledge.
        send_frame(8'h53, 1'b1, c_div);
        chk("b53_data", int'(rx_data), 8'h53);
        chk("b53_valid", int'(rx_valid), 1);
        chk("b53_ferr_pulses", ferr_pulses, 0);
        chk("b53_latency", lat, 11876);

        // Acknowledge lands on the exact cycle the next byte completes.
        // The line falls before edge N, the start is seen at edge N+2, and
        // the stop sample happens at edge N+2+11875.
        fork
            send_frame(8'h00, 1'b1, c_div);
            begin
                repeat (11877) @(posedge clk);
                @(negedge clk);
                ack_pulse();
                chk("same_cycle_valid", int'(rx_valid), 1);
                chk("same_cycle_ovr", int'(overrun), 0);
                chk("same_cycle_data", int'(rx_data), 8'h00);
            end
        join

        // Back-to-back byte with no acknowledge produces an overrun.
        send_frame(8'hFF, 1'b1, c_div);
        chk("ovr_data", int'(rx_data), 8'hFF);
        chk("ovr_valid", int'(rx_valid), 1);
        chk("ovr_flag", int'(overrun), 1);
        ack_pulse();
        repeat (2) @(negedge clk);
        chk("ack_clears_valid", int'(rx_valid), 0);
        chk("ovr_sticky", int'(overrun), 1);
        ack_pulse();
        chk("idle_ack_ignored", int'(rx_valid), 0);

        // Short low glitch is rejected at the mid-start check.
        rx = 1'b0;
        repeat (300) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_busy_before", int'(busy), 1);
        repeat (200) @(negedge clk);
        chk("glitch_busy_after", int'(busy), 0);
        chk("glitch_valid", int'(rx_valid), 0);
        chk("glitch_data", int'(rx_data), 8'hFF);

        // Bad stop bit followed by a long low line.
        ferr_pulses = 0;
        send_frame(8'hA5, 1'b0, 3000);
        chk("ferr_busy_held", int'(busy), 1);
        repeat (5) @(negedge clk);
        chk("ferr_busy_released", int'(busy), 0);
        chk("ferr_pulses", ferr_pulses, 1);
        chk("ferr_valid", int'(rx_valid), 0);
        chk("ferr_data", int'(rx_data), 8'hFF);

        // Reset in the middle of data bit 4 of 0x3C.
        rx = 1'b0;
        repeat (c_div) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h3C >> i) & 1;
            repeat (c_div) @(negedge clk);
        end
        rx = 1'b1;
        repeat (600) @(negedge clk);
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ovr", int'(overrun), 0);
        chk("rst_mid_data", int'(rx_data), 8'h00);
        nrst = 1'b1;
        repeat (c_div) @(negedge clk);
        send_frame(8'h81, 1'b1, c_div);
        chk("after_rst_data", int'(rx_data), 8'h81);
        chk("after_rst_valid", int'(rx_valid), 1);
        chk("after_rst_ovr", int'(overrun), 0);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
